alu_pipe_nb: RTL and testbench

Parametrised, pipelined successor to the 4-bit ALU stage. It takes W-bit operand pairs from the operand router and computes pre-add, then multiply, then post-add, with an optional running accumulator. It buffers results in a DEPTH-entry output FIFO so the decode side can issue one command per cycle under backpressure. It sits between op decode (command side) and the TX stage (result side).

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_pipe_nb_if.sv | 28 ++
 rtl/alu_res_fifo.sv | 45 ++++
 rtl/alu_pipe_nb.sv | 141 ++++++++++++++
 tb/tb_alu_pipe_nb.sv | 387 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: the wide-operand control word and the
// multiplier operand-select codes.
package alu_pkg;

    typedef struct packed {
        logic       pre_x_en;
        logic       pre_x_sub;
        logic       pre_y_en;
        logic       pre_y_sub;
        logic [2:0] mul_x_sel;
        logic       mul_x_en;
        logic [2:0] mul_y_sel;
        logic       mul_y_en;
        logic       post_en;
        logic       post_sub;
        logic       acc_en;
        logic       acc_clr;
    } alu_ctrl_w_t;

    localparam logic [2:0] MUL_SEL_IN0   = 3'd0;
    localparam logic [2:0] MUL_SEL_IN1   = 3'd1;
    localparam logic [2:0] MUL_SEL_PRE   = 3'd2;
    localparam logic [2:0] MUL_SEL_OTHER = 3'd3;
    localparam logic [2:0] MUL_SEL_ONE   = 3'd4;

endpackage

// File: rtl/alu_pipe_nb_if.sv
// Command/result bus between op decode (master) and the pipelined ALU (slave).
interface alu_pipe_nb_if #(
    parameter int W = 4
);
    localparam int P = 2 * W + 2;

    logic [W-1:0]         x0;
    logic [W-1:0]         x1;
    logic [W-1:0]         y0;
    logic [W-1:0]         y1;
    alu_pkg::alu_ctrl_w_t ctrl;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 res_valid;
    logic                 res_ready;
    logic [P-1:0]         res_q;
    logic                 carry_q;

    modport master (
        output x0, x1, y0, y1, ctrl, cmd_valid, res_ready,
        input  cmd_ready, res_valid, res_q, carry_q
    );

    modport slave (
        input  x0, x1, y0, y1, ctrl, cmd_valid, res_ready,
        output cmd_ready, res_valid, res_q, carry_q
    );
endinterface

// File: rtl/alu_res_fifo.sv
// Result FIFO: power-of-two depth, head visible combinationally, zero when empty.
module alu_res_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [WIDTH-1:0]       o_head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    // NOTE: storage is not reset; the head is masked by count, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
endmodule

// File: rtl/alu_pipe_nb.sv
// Pipelined ALU: S1 registers pre-add/multiply products, S2 post-adds and
// accumulates combinationally into a credit-checked result FIFO.
module alu_pipe_nb
    import alu_pkg::*;
#(
    parameter int W     = 4,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    alu_pipe_nb_if.slave bus
);
    localparam int PW = W + 1;
    localparam int P  = 2 * W + 2;
    localparam int CW = $clog2(DEPTH) + 1;

    function automatic logic [PW-1:0] pre_add(input logic en, input logic sub,
                                              input logic [W-1:0] in0, input logic [W-1:0] in1);
        logic [PW-1:0] a;
        logic [PW-1:0] b;
        a = PW'(in0);
        b = PW'(in1);
        pre_add = a;
        if (en) pre_add = sub ? (a - b) : (a + b);
    endfunction

    function automatic logic [PW-1:0] mul_pick(input logic [2:0] sel, input logic [W-1:0] in0,
                                               input logic [W-1:0] in1, input logic [PW-1:0] pre,
                                               input logic [W-1:0] other);
        case (sel)
            MUL_SEL_IN0:   mul_pick = PW'(in0);
            MUL_SEL_IN1:   mul_pick = PW'(in1);
            MUL_SEL_PRE:   mul_pick = pre;
            MUL_SEL_OTHER: mul_pick = PW'(other);
            MUL_SEL_ONE:   mul_pick = PW'(1);
            default:       mul_pick = '0;
        endcase
    endfunction

    function automatic logic [P-1:0] mul(input logic en, input logic [PW-1:0] m0,
                                         input logic [PW-1:0] m1);
        mul = en ? (P'(m0) * P'(m1)) : {m0, m1};
    endfunction

    logic [PW-1:0] w_pre_x, w_pre_y, w_m1_x, w_m1_y;
    logic [P-1:0]  w_prod_x, w_prod_y;
    logic          w_accept;

    assign w_pre_x  = pre_add(bus.ctrl.pre_x_en, bus.ctrl.pre_x_sub, bus.x0, bus.x1);
    assign w_pre_y  = pre_add(bus.ctrl.pre_y_en, bus.ctrl.pre_y_sub, bus.y0, bus.y1);
    assign w_m1_x   = mul_pick(bus.ctrl.mul_x_sel, bus.x0, bus.x1, w_pre_x, bus.y1);
    assign w_m1_y   = mul_pick(bus.ctrl.mul_y_sel, bus.y0, bus.y1, w_pre_y, bus.x1);
    assign w_prod_x = mul(bus.ctrl.mul_x_en, w_pre_x, w_m1_x);
    assign w_prod_y = mul(bus.ctrl.mul_y_en, w_pre_y, w_m1_y);
    assign w_accept = bus.cmd_valid && bus.cmd_ready;

    logic         r_s1_valid;
    logic [P-1:0] r_prod_x, r_prod_y;
    logic         r_post_en, r_post_sub, r_acc_en, r_acc_clr;
    logic [P-1:0] r_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_prod_x   <= '0;
            r_prod_y   <= '0;
            r_post_en  <= 1'b0;
            r_post_sub <= 1'b0;
            r_acc_en   <= 1'b0;
            r_acc_clr  <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_prod_x   <= w_prod_x;
                r_prod_y   <= w_prod_y;
                r_post_en  <= bus.ctrl.post_en;
                r_post_sub <= bus.ctrl.post_sub;
                r_acc_en   <= bus.ctrl.acc_en;
                r_acc_clr  <= bus.ctrl.acc_clr;
            end
        end
    end

    logic [P:0]   w_post_sum, w_acc_sum;
    logic [P-1:0] w_post_res, w_wr_res;
    logic         w_post_carry, w_wr_carry;

    // NOTE: every always_comb output gets a default first, so no path can leave a latch behind.
    always_comb begin
        w_post_sum   = r_post_sub ? ({1'b0, r_prod_x} - {1'b0, r_prod_y})
                                  : ({1'b0, r_prod_x} + {1'b0, r_prod_y});
        w_post_res   = {r_prod_x[W:0], r_prod_y[W:0]};
        w_post_carry = 1'b0;
        if (r_post_en) begin
            w_post_res   = w_post_sum[P-1:0];
            w_post_carry = w_post_sum[P];
        end
        w_acc_sum  = {1'b0, r_acc} + {1'b0, w_post_res};
        w_wr_res   = w_post_res;
        w_wr_carry = w_post_carry;
        if (!r_acc_clr && r_acc_en) begin
            w_wr_res   = w_acc_sum[P-1:0];
            w_wr_carry = w_acc_sum[P];
        end
    end

    // Both clear and accumulate leave acc holding exactly the value written to the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (r_s1_valid && (r_acc_clr || r_acc_en)) begin
            r_acc <= w_wr_res;
        end
    end

    logic [CW-1:0] w_count;
    logic [P:0]    w_head;
    logic          w_pop;
    logic [CW:0]   w_credit;

    alu_res_fifo #(
        .WIDTH (P + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_s1_valid),
        .i_data  ({w_wr_carry, w_wr_res}),
        .i_pop   (w_pop),
        .o_count (w_count),
        .o_head  (w_head)
    );

    // Credit check counts the S1 entry so it always finds a free FIFO slot.
    assign w_pop         = (w_count != '0) && bus.res_ready;
    assign w_credit      = {1'b0, w_count} + (CW + 1)'(r_s1_valid) - (CW + 1)'(w_pop);
    assign bus.cmd_ready = w_credit < (CW + 1)'(DEPTH);
    assign bus.res_valid = w_count != '0;
    assign bus.res_q     = w_head[P-1:0];
    assign bus.carry_q   = w_head[P];
endmodule

// File: tb/tb_alu_pipe_nb.sv
// Self-checking bench for alu_pipe_nb: directed scenarios plus randomized
// traffic against an arithmetic reference model with an in-order scoreboard.
module tb_alu_pipe_nb;
    import alu_pkg::*;

    localparam int W4 = 4;
    localparam int D4 = 2;
    localparam int P4 = 10;
    localparam int W8 = 8;
    localparam int D8 = 4;
    localparam int P8 = 18;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;
    longint acc4 = 0;
    longint acc8 = 0;

    typedef struct {
        longint val;
        bit     cy;
        int     avail;
    } exp_t;

    always #5 clk = ~clk;

    alu_pipe_nb_if #(.W(W4)) if4 ();
    alu_pipe_nb_if #(.W(W8)) if8 ();

    alu_pipe_nb #(.W(W4), .DEPTH(D4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    alu_pipe_nb #(.W(W8), .DEPTH(D8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

    function automatic longint pick(input logic [2:0] sel, input longint in0, input longint in1,
                                    input longint pre, input longint other);
        case (sel)
            3'd0:    return in0;
            3'd1:    return in1;
            3'd2:    return pre;
            3'd3:    return other;
            3'd4:    return 1;
            default: return 0;
        endcase
    endfunction

    // Reference: plain integer arithmetic with explicit modulo wrap.
    function automatic void model_cmd(input int w, input longint x0, input longint x1,
                                      input longint y0, input longint y1, input alu_ctrl_w_t c,
                                      inout longint acc, output longint val, output bit cy);
        longint mp, mr, px, py, mx, my, a, b, v, s;
        mp = longint'(1) << (w + 1);
        mr = longint'(1) << (2 * w + 2);
        px = !c.pre_x_en ? x0 : c.pre_x_sub ? (x0 - x1 + mp) % mp : (x0 + x1) % mp;
        py = !c.pre_y_en ? y0 : c.pre_y_sub ? (y0 - y1 + mp) % mp : (y0 + y1) % mp;
        mx = pick(c.mul_x_sel, x0, x1, px, y1);
        my = pick(c.mul_y_sel, y0, y1, py, x1);
        a  = c.mul_x_en ? px * mx : px * mp + mx;
        b  = c.mul_y_en ? py * my : py * mp + my;
        if (c.post_en) begin
            v   = c.post_sub ? (a - b + 2 * mr) % (2 * mr) : a + b;
            val = v % mr;
            cy  = v >= mr;
        end else begin
            val = (a % mp) * mp + (b % mp);
            cy  = 1'b0;
        end
        if (c.acc_clr) begin
            acc = val;
        end else if (c.acc_en) begin
            s   = acc + val;
            val = s % mr;
            cy  = s >= mr;
            acc = val;
        end
    endfunction

    function automatic alu_ctrl_w_t ctrl_a(input logic acc_en, input logic acc_clr);
        alu_ctrl_w_t c;
        c           = '0;
        c.pre_x_en  = 1'b1;
        c.mul_x_sel = MUL_SEL_PRE;
        c.mul_x_en  = 1'b1;
        c.pre_y_en  = 1'b1;
        c.pre_y_sub = 1'b1;
        c.mul_y_sel = MUL_SEL_ONE;
        c.mul_y_en  = 1'b1;
        c.post_en   = 1'b1;
        c.acc_en    = acc_en;
        c.acc_clr   = acc_clr;
        return c;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        if4.cmd_valid = 1'b0; if4.res_ready = 1'b0;
        if8.cmd_valid = 1'b0; if8.res_ready = 1'b0;
        @(negedge clk);
        rst  = 1'b0;
        acc4 = 0;
        acc8 = 0;
    endtask

    // Issue one command on if4, wait for its result and pop it; X on timeout.
    task automatic send_one4(input logic [W4-1:0] x0, x1, y0, y1, input alu_ctrl_w_t c,
                             output logic [P4-1:0] res, output logic cy);
        bit got;
        res = 'x; cy = 1'bx; got = 0;
        @(negedge clk);
        if4.x0 = x0; if4.x1 = x1; if4.y0 = y0; if4.y1 = y1; if4.ctrl = c;
        if4.cmd_valid = 1'b1; if4.res_ready = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            #1 got = if4.cmd_ready;
            @(posedge clk);
            @(negedge clk);
        end
        if4.cmd_valid = 1'b0;
        for (int i = 0; i < 10 && got; i++) begin
            #1;
            if (if4.res_valid) begin
                res = if4.res_q; cy = if4.carry_q; if4.res_ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                if4.res_ready = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic send_one8(input logic [W8-1:0] x0, x1, y0, y1, input alu_ctrl_w_t c,
                             output logic [P8-1:0] res, output logic cy);
        bit got;
        res = 'x; cy = 1'bx; got = 0;
        @(negedge clk);
        if8.x0 = x0; if8.x1 = x1; if8.y0 = y0; if8.y1 = y1; if8.ctrl = c;
        if8.cmd_valid = 1'b1; if8.res_ready = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            #1 got = if8.cmd_ready;
            @(posedge clk);
            @(negedge clk);
        end
        if8.cmd_valid = 1'b0;
        for (int i = 0; i < 10 && got; i++) begin
            #1;
            if (if8.res_valid) begin
                res = if8.res_q; cy = if8.carry_q; if8.res_ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                if8.res_ready = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_total++; if (if4.cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got=%b exp=1", if4.cmd_ready); else n_pass++;
        n_total++; if (if4.res_valid !== 1'b0) $display("FAIL reset_res_valid got=%b exp=0", if4.res_valid); else n_pass++;
        n_total++; if (if4.res_q !== '0) $display("FAIL reset_res_q got=%h exp=0", if4.res_q); else n_pass++;
        n_total++; if (if4.carry_q !== 1'b0) $display("FAIL reset_carry_q got=%b exp=0", if4.carry_q); else n_pass++;
        n_total++; if (if8.res_valid !== 1'b0) $display("FAIL reset_res_valid_w8 got=%b exp=0", if8.res_valid); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        @(negedge clk);
        if4.x0 = 4'd3; if4.x1 = 4'd2; if4.y0 = 4'd4; if4.y1 = 4'd1; if4.ctrl = ctrl_a(1'b0, 1'b0);
        if4.cmd_valid = 1'b1; if4.res_ready = 1'b0;
        #1;
        n_total++; if (if4.cmd_ready !== 1'b1) $display("FAIL basic_ready got=%b exp=1", if4.cmd_ready); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        if4.cmd_valid = 1'b0;
        #1;
        n_total++; if (if4.res_valid !== 1'b0) $display("FAIL basic_valid_early got=%b exp=0", if4.res_valid); else n_pass++;
        @(negedge clk);
        #1;
        n_total++; if (if4.res_valid !== 1'b1) $display("FAIL basic_valid got=%b exp=1", if4.res_valid); else n_pass++;
        n_total++; if (if4.res_q !== 10'd28) $display("FAIL basic_res got=%0d exp=28", if4.res_q); else n_pass++;
        n_total++; if (if4.carry_q !== 1'b0) $display("FAIL basic_carry got=%b exp=0", if4.carry_q); else n_pass++;
        if4.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if4.res_ready = 1'b0;
        #1;
        n_total++; if (if4.res_valid !== 1'b0) $display("FAIL basic_drained got=%b exp=0", if4.res_valid); else n_pass++;
        n_total++; if (if4.res_q !== '0) $display("FAIL basic_empty_q got=%h exp=0", if4.res_q); else n_pass++;
    endtask

    task automatic test_sub_borrow();
        alu_ctrl_w_t c;
        logic [P4-1:0] r;
        logic cy;
        c = '0;
        c.mul_x_sel = MUL_SEL_ONE; c.mul_x_en = 1'b1;
        c.mul_y_sel = MUL_SEL_ONE; c.mul_y_en = 1'b1;
        c.post_en = 1'b1; c.post_sub = 1'b1;
        send_one4(4'd1, 4'd0, 4'd2, 4'd0, c, r, cy);
        n_total++; if (r !== 10'h3FF) $display("FAIL borrow_res got=%h exp=3ff", r); else n_pass++;
        n_total++; if (cy !== 1'b1) $display("FAIL borrow_carry got=%b exp=1", cy); else n_pass++;
    endtask

    task automatic test_accumulator();
        logic [P4-1:0] r;
        logic cy;
        send_one4(4'd3, 4'd2, 4'd4, 4'd1, ctrl_a(1'b0, 1'b1), r, cy);
        n_total++; if (r !== 10'd28) $display("FAIL acc_clr got=%0d exp=28", r); else n_pass++;
        send_one4(4'd3, 4'd2, 4'd4, 4'd1, ctrl_a(1'b1, 1'b0), r, cy);
        n_total++; if (r !== 10'd56) $display("FAIL acc_en got=%0d exp=56", r); else n_pass++;
        send_one4(4'd3, 4'd2, 4'd4, 4'd1, '0, r, cy);
        n_total++; if (r !== 10'd100) $display("FAIL acc_pass got=%0d exp=100", r); else n_pass++;
        n_total++; if (cy !== 1'b0) $display("FAIL acc_pass_carry got=%b exp=0", cy); else n_pass++;
        send_one4(4'd3, 4'd2, 4'd4, 4'd1, ctrl_a(1'b1, 1'b0), r, cy);
        n_total++; if (r !== 10'd84) $display("FAIL acc_held got=%0d exp=84", r); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [W4-1:0] bx0[4], bx1[4], by0[4], by1[4];
        alu_ctrl_w_t   bc[4];
        longint        ev[4];
        bit            ec[4];
        int k, p, first, last;
        bit acc, pv;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bx0[i] = W4'($urandom); bx1[i] = W4'($urandom);
            by0[i] = W4'($urandom); by1[i] = W4'($urandom);
            bc[i]  = 16'($urandom);
            model_cmd(W4, bx0[i], bx1[i], by0[i], by1[i], bc[i], acc4, ev[i], ec[i]);
        end
        k = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if4.x0 = bx0[k]; if4.x1 = bx1[k]; if4.y0 = by0[k]; if4.y1 = by1[k]; if4.ctrl = bc[k];
            if4.cmd_valid = 1'b1;
            #1 acc = if4.cmd_ready;
            @(posedge clk);
            if (acc) k++;
            @(negedge clk);
        end
        #1;
        n_total++; if (k !== 2) $display("FAIL bp_accepted got=%0d exp=2", k); else n_pass++;
        n_total++; if (if4.cmd_ready !== 1'b0) $display("FAIL bp_stall got=%b exp=0", if4.cmd_ready); else n_pass++;
        if4.res_ready = 1'b1;
        p = 0; first = -1; last = -1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (k < 4) begin
                if4.x0 = bx0[k]; if4.x1 = bx1[k]; if4.y0 = by0[k]; if4.y1 = by1[k]; if4.ctrl = bc[k];
            end
            if4.cmd_valid = k < 4;
            #1;
            if (if4.res_valid && p < 4) begin
                n_total++; if (if4.res_q !== P4'(ev[p])) $display("FAIL bp_res[%0d] got=%h exp=%h", p, if4.res_q, P4'(ev[p])); else n_pass++;
                n_total++; if (if4.carry_q !== ec[p]) $display("FAIL bp_carry[%0d] got=%b exp=%b", p, if4.carry_q, ec[p]); else n_pass++;
            end
            acc = if4.cmd_valid && if4.cmd_ready;
            pv  = if4.res_valid;
            @(posedge clk);
            if (acc) k++;
            if (pv) begin
                if (first < 0) first = cyc;
                last = cyc;
                p++;
            end
            @(negedge clk);
        end
        if4.res_ready = 1'b0;
        n_total++; if (p !== 4) $display("FAIL bp_pops got=%0d exp=4", p); else n_pass++;
        n_total++; if (last - first !== 3) $display("FAIL bp_rate span got=%0d exp=3", last - first); else n_pass++;
    endtask

    task automatic test_random();
        exp_t q[$];
        int e;
        bit hold, exp_valid, exp_pop, exp_ready, acc;
        longint v;
        bit cy;
        do_reset();
        q.delete();
        e = 0; hold = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!hold) begin
                if4.x0 = W4'($urandom); if4.x1 = W4'($urandom);
                if4.y0 = W4'($urandom); if4.y1 = W4'($urandom);
                if4.ctrl = 16'($urandom);
                if4.cmd_valid = $urandom_range(0, 9) < 7;
            end
            if4.res_ready = $urandom_range(0, 9) < 6;
            #1;
            exp_valid = q.size() > 0 && q[0].avail <= e;
            exp_pop   = exp_valid && if4.res_ready;
            exp_ready = (q.size() - (exp_pop ? 1 : 0)) < D4;
            n_total++; if (if4.cmd_ready !== exp_ready) $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, if4.cmd_ready, exp_ready); else n_pass++;
            n_total++; if (if4.res_valid !== exp_valid) $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, if4.res_valid, exp_valid); else n_pass++;
            if (exp_valid) begin
                n_total++; if (if4.res_q !== P4'(q[0].val)) $display("FAIL rnd_res cyc=%0d got=%h exp=%h", cyc, if4.res_q, P4'(q[0].val)); else n_pass++;
                n_total++; if (if4.carry_q !== q[0].cy) $display("FAIL rnd_carry cyc=%0d got=%b exp=%b", cyc, if4.carry_q, q[0].cy); else n_pass++;
            end else begin
                n_total++; if (if4.res_q !== '0) $display("FAIL rnd_empty_q cyc=%0d got=%h exp=0", cyc, if4.res_q); else n_pass++;
            end
            acc = if4.cmd_valid && exp_ready;
            @(posedge clk);
            e++;
            if (exp_pop) void'(q.pop_front());
            if (acc) begin
                model_cmd(W4, if4.x0, if4.x1, if4.y0, if4.y1, if4.ctrl, acc4, v, cy);
                q.push_back('{val: v, cy: cy, avail: e + 1});
            end
            hold = if4.cmd_valid && !acc;
            @(negedge clk);
        end
        if4.cmd_valid = 1'b0;
        if4.res_ready = 1'b0;
    endtask

    task automatic test_w8();
        alu_ctrl_w_t c;
        logic [P8-1:0] r;
        logic cy;
        logic [W8-1:0] a0, a1, b0, b1;
        longint v;
        bit ecy;
        do_reset();
        c = '0;
        c.pre_x_en = 1'b1; c.mul_x_sel = MUL_SEL_PRE; c.mul_x_en = 1'b1;
        c.mul_y_en = 1'b1; c.post_en = 1'b1;
        send_one8(8'd255, 8'd255, 8'd0, 8'd0, c, r, cy);
        n_total++; if (r !== 18'd260100) $display("FAIL w8_res got=%0d exp=260100", r); else n_pass++;
        n_total++; if (cy !== 1'b0) $display("FAIL w8_carry got=%b exp=0", cy); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            a0 = W8'($urandom); a1 = W8'($urandom); b0 = W8'($urandom); b1 = W8'($urandom);
            c = 16'($urandom);
            model_cmd(W8, a0, a1, b0, b1, c, acc8, v, ecy);
            send_one8(a0, a1, b0, b1, c, r, cy);
            n_total++; if (r !== P8'(v)) $display("FAIL w8_rnd_res[%0d] got=%h exp=%h", i, r, P8'(v)); else n_pass++;
            n_total++; if (cy !== ecy) $display("FAIL w8_rnd_carry[%0d] got=%b exp=%b", i, cy, ecy); else n_pass++;
        end
    endtask

    task automatic test_reset_midflight();
        logic [P8-1:0] r;
        logic cy;
        do_reset();
        @(negedge clk);
        if8.x0 = 8'd3; if8.x1 = 8'd2; if8.y0 = 8'd4; if8.y1 = 8'd1; if8.ctrl = ctrl_a(1'b0, 1'b1);
        if8.cmd_valid = 1'b1; if8.res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (if8.res_valid !== 1'b1) $display("FAIL mid_buffered got=%b exp=1", if8.res_valid); else n_pass++;
        if8.cmd_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        n_total++; if (if8.res_valid !== 1'b0) $display("FAIL mid_res_valid got=%b exp=0", if8.res_valid); else n_pass++;
        n_total++; if (if8.res_q !== '0) $display("FAIL mid_res_q got=%h exp=0", if8.res_q); else n_pass++;
        n_total++; if (if8.cmd_ready !== 1'b1) $display("FAIL mid_cmd_ready got=%b exp=1", if8.cmd_ready); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        send_one8(8'd3, 8'd2, 8'd4, 8'd1, ctrl_a(1'b1, 1'b0), r, cy);
        n_total++; if (r !== 18'd28) $display("FAIL mid_acc_after got=%0d exp=28", r); else n_pass++;
        n_total++; if (cy !== 1'b0) $display("FAIL mid_acc_carry got=%b exp=0", cy); else n_pass++;
    endtask

    initial begin
        if4.x0 = '0; if4.x1 = '0; if4.y0 = '0; if4.y1 = '0; if4.ctrl = '0;
        if4.cmd_valid = 1'b0; if4.res_ready = 1'b0;
        if8.x0 = '0; if8.x1 = '0; if8.y0 = '0; if8.y1 = '0; if8.ctrl = '0;
        if8.cmd_valid = 1'b0; if8.res_ready = 1'b0;
        test_reset();
        test_basic();
        test_sub_borrow();
        test_accumulator();
        test_backpressure();
        test_random();
        test_w8();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end
endmodule
